// File: rtl/note_lane_engine_pkg.sv
// Shared types and helpers for the note lane engine.
//   grade_t        : outcome of judging one lane in one cycle
//   LANE_*         : lane direction within a player (left, up, right, down)
//   lane_index     : (player, lane) -> flattened lane number
//   slot_bit       : (player, lane, slot) -> bit offset into slot_active
//   slot_y_bit     : (player, lane, slot) -> bit offset into slot_y
//   abs_diff       : absolute difference of two integers
package note_lane_pkg;

    typedef enum logic [1:0] {
        GRADE_NONE,
        GRADE_GOOD,
        GRADE_PERFECT,
        GRADE_MISS
    } grade_t;

    localparam int LANE_LEFT  = 0;
    localparam int LANE_UP    = 1;
    localparam int LANE_RIGHT = 2;
    localparam int LANE_DOWN  = 3;

    function automatic int lane_index(input int player, input int lane, input int lanes);
        return player * lanes + lane;
    endfunction

    function automatic int slot_bit(input int player, input int lane, input int slot,
                                    input int lanes, input int slots);
        return lane_index(player, lane, lanes) * slots + slot;
    endfunction

    function automatic int slot_y_bit(input int player, input int lane, input int slot,
                                      input int lanes, input int slots, input int y_w);
        return slot_bit(player, lane, slot, lanes, slots) * y_w;
    endfunction

    function automatic int abs_diff(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/note_lane_engine_if.sv
// Bus between the game controller and the note lane engine.
//   Controller -> engine : enable, spawn_valid, spawn_mask, keys
//   Engine -> controller : slot_active, slot_y, lane_flash, hit_perfect,
//                          hit_good, miss, spawn_overflow
// Handshake: spawn_mask is consumed in every cycle where spawn_valid=1 and
// enable=1; there is no ready, a request that finds no free slot is dropped
// and reported through the spawn_overflow pulse one cycle later.
interface note_lane_engine_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int LANES       = 4,
    parameter int SLOTS       = 2,
    parameter int Y_W         = 7
) ();
    localparam int NL = NUM_PLAYERS * LANES;

    logic                      enable;
    logic                      spawn_valid;
    logic [NL-1:0]             spawn_mask;
    logic [NL-1:0]             keys;
    logic [NL*SLOTS-1:0]       slot_active;
    logic [NL*SLOTS*Y_W-1:0]   slot_y;
    logic [NL-1:0]             lane_flash;
    logic [NUM_PLAYERS-1:0]    hit_perfect;
    logic [NUM_PLAYERS-1:0]    hit_good;
    logic [NUM_PLAYERS-1:0]    miss;
    logic                      spawn_overflow;

    modport master (
        output enable, spawn_valid, spawn_mask, keys,
        input  slot_active, slot_y, lane_flash, hit_perfect, hit_good, miss, spawn_overflow
    );

    modport slave (
        input  enable, spawn_valid, spawn_mask, keys,
        output slot_active, slot_y, lane_flash, hit_perfect, hit_good, miss, spawn_overflow
    );
endinterface

// File: rtl/note_lane_engine_lane_slot_pool.sv
// One lane: SLOTS note registers, slot allocation, key judging, miss
// detection and the lane flash timer.
//   clk, reset         : clock, asynchronous active-high reset
//   enable             : 0 freezes every register in the lane
//   tick               : one-row move strobe
//   spawn_req          : allocate a new note at y=0
//   key_edge           : rising edge of this lane's key
//   grade              : hit grade this cycle (combinational)
//   miss_evt, overflow : a note was missed / a spawn was dropped (combinational)
//   active, y_flat     : registered slot state
//   flash              : registered lane flash
module lane_slot_pool
    import note_lane_pkg::*;
#(
    parameter int SLOTS         = 2,
    parameter int Y_W           = 7,
    parameter int TARGET_Y      = 90,
    parameter int PERFECT_RANGE = 2,
    parameter int GOOD_RANGE    = 6,
    parameter int FLASH_LEN     = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 tick,
    input  logic                 spawn_req,
    input  logic                 key_edge,
    output grade_t               grade,
    output logic                 miss_evt,
    output logic                 overflow,
    output logic [SLOTS-1:0]     active,
    output logic [SLOTS*Y_W-1:0] y_flat,
    output logic                 flash
);
    localparam int MISS_Y = TARGET_Y + GOOD_RANGE;
    localparam int FW     = (FLASH_LEN > 1) ? $clog2(FLASH_LEN) : 1;

    logic [SLOTS-1:0] active_q;
    logic [Y_W-1:0]   y_q [SLOTS];
    logic [FW-1:0]    flash_cnt;
    logic             flash_q;

    logic [SLOTS-1:0] hit_sel;
    logic [SLOTS-1:0] miss_sel;
    logic [SLOTS-1:0] spawn_sel;
    logic             found;
    logic             free_found;
    int               best_idx;
    int               best_dist;
    logic [Y_W-1:0]   best_y;

    // Winner among in-window notes: largest y; strict '>' keeps the lowest
    // index on a tie because slots are scanned upward.
    always_comb begin
        found     = 1'b0;
        best_idx  = 0;
        best_dist = 0;
        best_y    = '0;
        for (int s = 0; s < SLOTS; s++) begin
            if (active_q[s] && abs_diff(int'(y_q[s]), TARGET_Y) <= GOOD_RANGE) begin
                if (!found || y_q[s] > best_y) begin
                    found     = 1'b1;
                    best_idx  = s;
                    best_y    = y_q[s];
                    best_dist = abs_diff(int'(y_q[s]), TARGET_Y);
                end
            end
        end
    end

    always_comb begin
        hit_sel    = '0;
        miss_sel   = '0;
        spawn_sel  = '0;
        free_found = 1'b0;
        grade      = GRADE_NONE;
        miss_evt   = 1'b0;
        overflow   = 1'b0;
        if (enable) begin
            if (key_edge && found) begin
                for (int s = 0; s < SLOTS; s++) begin
                    if (s == best_idx) hit_sel[s] = 1'b1;
                end
                grade = (best_dist <= PERFECT_RANGE) ? GRADE_PERFECT : GRADE_GOOD;
            end
            // A hit on the same slot wins over the miss.
            for (int s = 0; s < SLOTS; s++) begin
                if (tick && active_q[s] && !hit_sel[s] && y_q[s] == Y_W'(MISS_Y))
                    miss_sel[s] = 1'b1;
            end
            miss_evt = |miss_sel;
            // Only slots free at the start of the cycle are candidates, so a
            // slot freed by this cycle's hit or miss is not reused yet.
            if (spawn_req) begin
                for (int s = 0; s < SLOTS; s++) begin
                    if (!free_found && !active_q[s]) begin
                        spawn_sel[s] = 1'b1;
                        free_found   = 1'b1;
                    end
                end
                overflow = !free_found;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q  <= '0;
            for (int s = 0; s < SLOTS; s++) y_q[s] <= '0;
            flash_cnt <= '0;
            flash_q   <= 1'b0;
        end else if (enable) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (hit_sel[s] || miss_sel[s]) begin
                    active_q[s] <= 1'b0;
                end else if (spawn_sel[s]) begin
                    active_q[s] <= 1'b1;
                    y_q[s]      <= '0;
                end else if (tick && active_q[s]) begin
                    y_q[s] <= y_q[s] + 1'b1;
                end
            end
            // Flash stays high for FLASH_LEN cycles after the hit edge.
            if (|hit_sel) begin
                flash_cnt <= FW'(FLASH_LEN - 1);
                flash_q   <= 1'b1;
            end else if (flash_cnt != '0) begin
                flash_cnt <= flash_cnt - 1'b1;
            end else begin
                flash_q <= 1'b0;
            end
        end
    end

    assign active = active_q;
    assign flash  = flash_q;

    for (genvar g = 0; g < SLOTS; g++) begin : g_y
        assign y_flat[g*Y_W +: Y_W] = y_q[g];
    end

endmodule

// File: rtl/note_lane_engine.sv
// Rhythm game gameplay core: NUM_PLAYERS x LANES lanes of falling notes.
//   CLOCK_50 : clock
//   reset    : asynchronous, active-high
//   bus      : note_lane_engine_if slave (controls in, slot state and
//              per-player hit/miss pulses out, all outputs registered)
// Holds the move divider, the key edge detector and the per-player pulse
// registers; each lane is a lane_slot_pool.
module note_lane_engine
    import note_lane_pkg::*;
#(
    parameter int NUM_PLAYERS   = 2,
    parameter int LANES         = 4,
    parameter int SLOTS         = 2,
    parameter int Y_W           = 7,
    parameter int TARGET_Y      = 90,
    parameter int PERFECT_RANGE = 2,
    parameter int GOOD_RANGE    = 6,
    parameter int MOVE_DIV      = 1000000,
    parameter int FLASH_LEN     = 1000000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    note_lane_engine_if.slave  bus
);
    localparam int NL = NUM_PLAYERS * LANES;
    localparam int DW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    if (TARGET_Y + GOOD_RANGE >= (1 << Y_W) - 1) begin : g_bad_y
        $error("note_lane_engine: TARGET_Y+GOOD_RANGE must be below 2**Y_W-1");
    end
    if (GOOD_RANGE < PERFECT_RANGE) begin : g_bad_range
        $error("note_lane_engine: GOOD_RANGE must be >= PERFECT_RANGE");
    end

    logic [DW-1:0]          div_q;
    logic                   tick;
    logic [NL-1:0]          prev_keys;
    logic [NL-1:0]          key_edge;
    logic [NL-1:0]          spawn_req;

    grade_t                 lane_grade [NL];
    logic [NL-1:0]          lane_miss;
    logic [NL-1:0]          lane_ovf;
    logic [NL*SLOTS-1:0]    slot_active_w;
    logic [NL*SLOTS*Y_W-1:0] slot_y_w;
    logic [NL-1:0]          flash_w;

    logic [NUM_PLAYERS-1:0] perf_n, good_n, miss_n;
    logic [NUM_PLAYERS-1:0] perf_q, good_q, miss_q;
    logic                   ovf_q;

    assign tick      = bus.enable && (div_q == DW'(MOVE_DIV - 1));
    assign key_edge  = bus.keys & ~prev_keys & {NL{bus.enable}};
    assign spawn_req = bus.spawn_mask & {NL{bus.spawn_valid & bus.enable}};

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            localparam int LI = lane_index(p, l, LANES);
            localparam int SB = slot_bit(p, l, 0, LANES, SLOTS);
            localparam int YB = slot_y_bit(p, l, 0, LANES, SLOTS, Y_W);

            lane_slot_pool #(
                .SLOTS         (SLOTS),
                .Y_W           (Y_W),
                .TARGET_Y      (TARGET_Y),
                .PERFECT_RANGE (PERFECT_RANGE),
                .GOOD_RANGE    (GOOD_RANGE),
                .FLASH_LEN     (FLASH_LEN)
            ) u_pool (
                .clk       (CLOCK_50),
                .reset     (reset),
                .enable    (bus.enable),
                .tick      (tick),
                .spawn_req (spawn_req[LI]),
                .key_edge  (key_edge[LI]),
                .grade     (lane_grade[LI]),
                .miss_evt  (lane_miss[LI]),
                .overflow  (lane_ovf[LI]),
                .active    (slot_active_w[SB +: SLOTS]),
                .y_flat    (slot_y_w[YB +: SLOTS*Y_W]),
                .flash     (flash_w[LI])
            );
        end
    end

    always_comb begin
        perf_n = '0;
        good_n = '0;
        miss_n = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_grade[p*LANES+l] == GRADE_PERFECT) perf_n[p] = 1'b1;
                if (lane_grade[p*LANES+l] == GRADE_GOOD)    good_n[p] = 1'b1;
                if (lane_miss[p*LANES+l])                   miss_n[p] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            div_q     <= '0;
            prev_keys <= '0;
            perf_q    <= '0;
            good_q    <= '0;
            miss_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            // Sampled even while frozen so resuming never sees a stale edge.
            prev_keys <= bus.keys;
            if (bus.enable) div_q <= tick ? '0 : div_q + 1'b1;
            // Lane events are already gated by enable, so pulses drop to 0.
            perf_q <= perf_n;
            good_q <= good_n;
            miss_q <= miss_n;
            ovf_q  <= |lane_ovf;
        end
    end

    assign bus.slot_active    = slot_active_w;
    assign bus.slot_y         = slot_y_w;
    assign bus.lane_flash     = flash_w;
    assign bus.hit_perfect    = perf_q;
    assign bus.hit_good       = good_q;
    assign bus.miss           = miss_q;
    assign bus.spawn_overflow = ovf_q;

endmodule

// File: tb/tb_note_lane_engine.sv
module tb_note_lane_engine;
    import note_lane_pkg::*;

    localparam int NP = 2;
    localparam int LN = 4;
    localparam int SL = 2;
    localparam int YW = 7;
    localparam int FLASH = 8;

    logic CLOCK_50;
    logic reset;
    int   checks;
    int   errors;

    note_lane_engine_if #(.NUM_PLAYERS(NP), .LANES(LN), .SLOTS(SL), .Y_W(YW)) ifc ();

    note_lane_engine #(
        .NUM_PLAYERS(NP), .LANES(LN), .SLOTS(SL), .Y_W(YW),
        .TARGET_Y(90), .PERFECT_RANGE(2), .GOOD_RANGE(6),
        .MOVE_DIV(4), .FLASH_LEN(FLASH)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (ifc)
    );

    // clock / reset
    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    // driver tasks
    task automatic cyc();
        @(negedge CLOCK_50);
    endtask

    function automatic logic [YW-1:0] get_y(input int li, input int s);
        return ifc.slot_y[(li*SL+s)*YW +: YW];
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        ifc.enable = 1'b1;
        ifc.spawn_valid = 1'b0;
        ifc.spawn_mask = '0;
        ifc.keys = '0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic spawn(input logic [NP*LN-1:0] mask);
        ifc.spawn_mask = mask;
        ifc.spawn_valid = 1'b1;
        cyc();
        ifc.spawn_valid = 1'b0;
        ifc.spawn_mask = '0;
    endtask

    task automatic wait_y(input int li, input int s, input int y, input int bound);
        bit hit_it;
        hit_it = 1'b0;
        for (int i = 0; i < bound && !hit_it; i++) begin
            if (ifc.slot_active[li*SL+s] && get_y(li, s) == YW'(y)) hit_it = 1'b1;
            else cyc();
        end
        checks++;
        if (!hit_it) begin
            errors++;
            $display("FAIL wait_y lane %0d slot %0d: got y=%0d required y=%0d", li, s, get_y(li, s), y);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (ifc.slot_active !== '0 || ifc.slot_y !== '0 || ifc.lane_flash !== '0 ||
            ifc.hit_perfect !== '0 || ifc.hit_good !== '0 || ifc.miss !== '0 ||
            ifc.spawn_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got active=%h flash=%h perf=%b good=%b miss=%b ovf=%b required all 0",
                     ifc.slot_active, ifc.lane_flash, ifc.hit_perfect, ifc.hit_good, ifc.miss, ifc.spawn_overflow);
        end
    endtask

    task automatic test_perfect();
        apply_reset();
        spawn(8'(1 << LANE_UP));
        checks++;
        if (ifc.slot_active !== 16'h0004 || get_y(1, 0) !== 7'd0) begin
            errors++;
            $display("FAIL spawn_up: got active=%h y=%0d required active=0004 y=0", ifc.slot_active, get_y(1, 0));
        end
        wait_y(1, 0, 1, 8);
        repeat (3) cyc();
        checks++;
        if (get_y(1, 0) !== 7'd1) begin
            errors++;
            $display("FAIL move_hold: got y=%0d required 1", get_y(1, 0));
        end
        cyc();
        checks++;
        if (get_y(1, 0) !== 7'd2) begin
            errors++;
            $display("FAIL move_tick: got y=%0d required 2", get_y(1, 0));
        end
        wait_y(1, 0, 90, 400);
        ifc.keys[1] = 1'b1;
        cyc();
        checks++;
        if (ifc.hit_perfect !== 2'b01 || ifc.hit_good !== 2'b00 || ifc.slot_active[2] !== 1'b0 ||
            ifc.lane_flash !== 8'h02) begin
            errors++;
            $display("FAIL perfect_hit: got perf=%b good=%b active2=%b flash=%h required 01 00 0 02",
                     ifc.hit_perfect, ifc.hit_good, ifc.slot_active[2], ifc.lane_flash);
        end
        cyc();
        checks++;
        if (ifc.hit_perfect !== 2'b00) begin
            errors++;
            $display("FAIL perfect_once: got perf=%b required 00", ifc.hit_perfect);
        end
        repeat (6) cyc();
        checks++;
        if (ifc.lane_flash[1] !== 1'b1) begin
            errors++;
            $display("FAIL flash_last: got %b required 1", ifc.lane_flash[1]);
        end
        cyc();
        checks++;
        if (ifc.lane_flash[1] !== 1'b0) begin
            errors++;
            $display("FAIL flash_end: got %b required 0", ifc.lane_flash[1]);
        end
        ifc.keys = '0;
    endtask

    task automatic test_good_and_early();
        apply_reset();
        spawn(8'h10);
        wait_y(4, 0, 95, 420);
        ifc.keys[4] = 1'b1;
        cyc();
        checks++;
        if (ifc.hit_good !== 2'b10 || ifc.hit_perfect !== 2'b00 || ifc.slot_active[8] !== 1'b0) begin
            errors++;
            $display("FAIL good_hit: got good=%b perf=%b active8=%b required 10 00 0",
                     ifc.hit_good, ifc.hit_perfect, ifc.slot_active[8]);
        end
        apply_reset();
        spawn(8'h10);
        wait_y(4, 0, 83, 400);
        ifc.keys[4] = 1'b1;
        cyc();
        checks++;
        if (ifc.hit_good !== 2'b00 || ifc.hit_perfect !== 2'b00 || ifc.miss !== 2'b00 ||
            ifc.slot_active[8] !== 1'b1) begin
            errors++;
            $display("FAIL early_press: got good=%b perf=%b miss=%b active8=%b required 00 00 00 1",
                     ifc.hit_good, ifc.hit_perfect, ifc.miss, ifc.slot_active[8]);
        end
        ifc.keys = '0;
        wait_y(4, 0, 84, 8);
    endtask

    task automatic test_miss();
        apply_reset();
        spawn(8'h01);
        wait_y(0, 0, 96, 420);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            checks++;
            if (i < 4 && (ifc.miss !== 2'b00 || ifc.slot_active[0] !== 1'b1)) begin
                errors++;
                $display("FAIL miss_early %0d: got miss=%b active=%b required 00 1", i, ifc.miss, ifc.slot_active[0]);
            end else if (i == 4 && (ifc.miss !== 2'b01 || ifc.slot_active[0] !== 1'b0 || get_y(0, 0) > 7'd96)) begin
                errors++;
                $display("FAIL miss_pulse: got miss=%b active=%b y=%0d required 01 0 <=96",
                         ifc.miss, ifc.slot_active[0], get_y(0, 0));
            end
        end
        cyc();
        checks++;
        if (ifc.miss !== 2'b00) begin
            errors++;
            $display("FAIL miss_once: got %b required 00", ifc.miss);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        cyc();
        cyc();
        ifc.spawn_mask = 8'h04;
        ifc.spawn_valid = 1'b1;
        cyc();
        checks++;
        if (ifc.slot_active[5:4] !== 2'b01 || ifc.spawn_overflow !== 1'b0) begin
            errors++;
            $display("FAIL spawn_1: got slots=%b ovf=%b required 01 0", ifc.slot_active[5:4], ifc.spawn_overflow);
        end
        cyc();
        checks++;
        if (ifc.slot_active[5:4] !== 2'b11 || ifc.spawn_overflow !== 1'b0 ||
            get_y(2, 0) !== 7'd1 || get_y(2, 1) !== 7'd0) begin
            errors++;
            $display("FAIL spawn_2: got slots=%b ovf=%b y0=%0d y1=%0d required 11 0 1 0",
                     ifc.slot_active[5:4], ifc.spawn_overflow, get_y(2, 0), get_y(2, 1));
        end
        cyc();
        checks++;
        if (ifc.slot_active[5:4] !== 2'b11 || ifc.spawn_overflow !== 1'b1) begin
            errors++;
            $display("FAIL spawn_3: got slots=%b ovf=%b required 11 1", ifc.slot_active[5:4], ifc.spawn_overflow);
        end
        ifc.spawn_valid = 1'b0;
        ifc.spawn_mask = '0;
        cyc();
        checks++;
        if (ifc.spawn_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_once: got %b required 0", ifc.spawn_overflow);
        end
        wait_y(2, 0, 88, 400);
        ifc.keys[2] = 1'b1;
        cyc();
        checks++;
        if (ifc.hit_perfect !== 2'b01 || ifc.hit_good !== 2'b00 || ifc.slot_active[5:4] !== 2'b10) begin
            errors++;
            $display("FAIL older_first: got perf=%b good=%b slots=%b required 01 00 10",
                     ifc.hit_perfect, ifc.hit_good, ifc.slot_active[5:4]);
        end
        ifc.keys[2] = 1'b0;
        cyc();
        ifc.keys[2] = 1'b1;
        cyc();
        checks++;
        if (ifc.hit_good !== 2'b01 || ifc.hit_perfect !== 2'b00 || ifc.slot_active[5:4] !== 2'b00) begin
            errors++;
            $display("FAIL second_note: got perf=%b good=%b slots=%b required 00 01 00",
                     ifc.hit_perfect, ifc.hit_good, ifc.slot_active[5:4]);
        end
        ifc.keys = '0;
    endtask

    task automatic test_hit_over_miss_and_freeze();
        bit bad;
        apply_reset();
        spawn(8'h01);
        wait_y(0, 0, 96, 420);
        repeat (3) cyc();
        ifc.keys[0] = 1'b1;
        cyc();
        checks++;
        if (ifc.hit_good !== 2'b01 || ifc.miss !== 2'b00 || ifc.slot_active[0] !== 1'b0) begin
            errors++;
            $display("FAIL hit_beats_miss: got good=%b miss=%b active=%b required 01 00 0",
                     ifc.hit_good, ifc.miss, ifc.slot_active[0]);
        end
        spawn(8'h08);
        wait_y(3, 0, 2, 20);
        ifc.enable = 1'b0;
        ifc.spawn_valid = 1'b1;
        ifc.spawn_mask = 8'h08;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (ifc.hit_perfect !== 2'b00 || ifc.hit_good !== 2'b00 || ifc.miss !== 2'b00 ||
                ifc.spawn_overflow !== 1'b0 || ifc.slot_active[7:6] !== 2'b01 || get_y(3, 0) !== 7'd2)
                bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL freeze_hold: got slots=%b y=%0d perf=%b good=%b required 01 2 00 00",
                     ifc.slot_active[7:6], get_y(3, 0), ifc.hit_perfect, ifc.hit_good);
        end
        ifc.spawn_valid = 1'b0;
        ifc.spawn_mask = '0;
        ifc.enable = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (ifc.hit_perfect !== 2'b00 || ifc.hit_good !== 2'b00 || get_y(3, 0) !== 7'd2) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL resume_no_edge: got perf=%b good=%b y=%0d required 00 00 2",
                     ifc.hit_perfect, ifc.hit_good, get_y(3, 0));
        end
        cyc();
        checks++;
        if (get_y(3, 0) !== 7'd3) begin
            errors++;
            $display("FAIL divider_held: got y=%0d required 3", get_y(3, 0));
        end
        ifc.keys = '0;
    endtask

    task automatic test_reset_mid_flight();
        apply_reset();
        spawn(8'h1F);
        checks++;
        if (ifc.slot_active !== 16'h0155) begin
            errors++;
            $display("FAIL five_notes: got %h required 0155", ifc.slot_active);
        end
        repeat (5) cyc();
        reset = 1'b1;
        #1;
        checks++;
        if (ifc.slot_active !== '0 || ifc.slot_y !== '0 || ifc.lane_flash !== '0) begin
            errors++;
            $display("FAIL async_clear: got active=%h flash=%h required 0 0", ifc.slot_active, ifc.lane_flash);
        end
        cyc();
        reset = 1'b0;
        cyc();
        checks++;
        if (ifc.slot_active !== '0 || ifc.hit_perfect !== '0 || ifc.hit_good !== '0 ||
            ifc.miss !== '0 || ifc.spawn_overflow !== 1'b0) begin
            errors++;
            $display("FAIL post_release: got active=%h perf=%b good=%b miss=%b required all 0",
                     ifc.slot_active, ifc.hit_perfect, ifc.hit_good, ifc.miss);
        end
        spawn(8'h01);
        checks++;
        if (ifc.slot_active !== 16'h0001 || ifc.slot_y !== '0) begin
            errors++;
            $display("FAIL realloc_slot0: got active=%h y0=%0d required 0001 0", ifc.slot_active, get_y(0, 0));
        end
    endtask

    // sequence and final report
    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        ifc.enable = 1'b0;
        ifc.spawn_valid = 1'b0;
        ifc.spawn_mask = '0;
        ifc.keys = '0;
        test_reset();
        test_perfect();
        test_good_and_early();
        test_miss();
        test_back_to_back();
        test_hit_over_miss_and_freeze();
        test_reset_mid_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
